// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width,
// the arbiter state encoding and a counter sizing helper.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_e;

  // Width of a counter that must hold values 0..max(a,b); never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin request picker: returns the first active request found when
// searching from i_ptr upwards, wrapping at NUM_REQ-1.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [IDX_W-1:0]   o_grant_idx
);

  // i_ptr + k, wrapped into 0..NUM_REQ-1 (i_ptr is always < NUM_REQ).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk the offsets from farthest to nearest so the nearest active request wins.
  always_comb begin
    o_any       = 1'b0;
    o_grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[wrap_add(i_ptr, k)]) begin
        o_any       = 1'b1;
        o_grant_idx = wrap_add(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ byte
// producers. One byte per grant; optional inter-frame gap and watchdog.
//
// Handshake: i_req[i] acts as valid for byte slice i, o_ack[i] as a one-cycle
// ready/take pulse. The producer holds its slice stable while i_req[i]=1 and
// o_ack[i]=0; it may drop i_req[i] before o_ack[i] and is then not granted.
// The byte is transferred in the cycle o_ack[i]=1 (which always coincides
// with o_tx_start=1).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int GAP_CYCLES  = 0,
  parameter int WDOG_CYCLES = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_din,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_owner,
  output logic                          o_timeout_err,
  output logic [1:0]                    o_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(GAP_CYCLES, WDOG_CYCLES);

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_START = ARB_START;
  localparam logic [1:0] ST_WAIT  = ARB_WAIT;
  localparam logic [1:0] ST_GAP   = ARB_GAP;

  // Terminal counter values; only consulted when the feature is enabled.
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES  > 0) ? CNT_W'(GAP_CYCLES - 1)  : '0;
  localparam logic [CNT_W-1:0] WDOG_LAST = (WDOG_CYCLES > 0) ? CNT_W'(WDOG_CYCLES - 1) : '0;

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_din;
  logic                  r_busy;
  logic [IDX_W-1:0]      r_owner;
  logic                  r_timeout_err;

  logic                  w_any;
  logic [IDX_W-1:0]      w_grant;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [IDX_W-1:0]      w_next_ptr;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req       (i_req),
    .i_ptr       (r_ptr),
    .o_any       (w_any),
    .o_grant_idx (w_grant)
  );

  // Select the granted byte slice and the pointer value just past the grant.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDX_W'(i)) w_gnt_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    w_next_ptr = (w_grant == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant + IDX_W'(1);
  end

  // Arbitration FSM with frame/gap/watchdog counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_ack         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_din      <= '0;
      r_busy        <= 1'b0;
      r_owner       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low; only the grant or abort raises them.
      r_ack         <= '0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_START;
            r_tx_din   <= w_gnt_data;
            r_owner    <= w_grant;
            r_ptr      <= w_next_ptr;
            r_ack      <= NUM_REQ'(1) << w_grant;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
        end
        ST_WAIT: begin
          // tx_done takes priority over a watchdog expiry in the same cycle.
          if (i_tx_done) begin
            r_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if ((WDOG_CYCLES > 0) && (r_cnt == WDOG_LAST)) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
          end else if (WDOG_CYCLES > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_ack         = r_ack;
  assign o_tx_start    = r_tx_start;
  assign o_tx_din      = r_tx_din;
  assign o_busy        = r_busy;
  assign o_owner       = r_owner;
  assign o_timeout_err = r_timeout_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8, GAP_CYCLES=3,
// WDOG_CYCLES=32): directed vectors, scoreboard of expected grants.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int GAP  = 3;
  localparam int WDOG = 32;
  localparam int SBW  = 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  data;
  logic              done_auto;
  logic              done_force;
  logic              tx_done;
  logic [NR-1:0]     ack;
  logic              tx_start;
  logic [DW-1:0]     tx_din;
  logic              busy;
  logic [1:0]        owner;
  logic              timeout_err;
  logic [1:0]        state;

  assign tx_done = done_auto | done_force;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_WIDTH  (DW),
    .GAP_CYCLES  (GAP),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_data        (data),
    .o_ack         (ack),
    .o_tx_start    (tx_start),
    .o_tx_din      (tx_din),
    .i_tx_done     (tx_done),
    .o_busy        (busy),
    .o_owner       (owner),
    .o_timeout_err (timeout_err),
    .o_state       (state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int done_cyc = 0;
  int done_delay = 10;
  int ack1_cnt = 0;
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] sb_e;
  logic [NR-1:0]  sb_ack;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("ack_with_start", {31'b0, (ack != '0)}, {31'b0, tx_start});
      if (ack[1]) ack1_cnt++;
      if (tx_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        check("start_expected", {31'b0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) begin
          sb_e   = exp_q.pop_front();
          sb_ack = NR'(1) << sb_e[SBW-1:DW];
          check("grant_ack",   ack,    sb_ack);
          check("grant_din",   tx_din, sb_e[DW-1:0]);
          check("grant_owner", owner,  sb_e[SBW-1:DW]);
          check("grant_busy",  busy,   1);
        end
      end
    end
  end

  // ---------------- uart_tx responder ----------------
  initial begin
    done_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst && tx_start && done_delay > 0) begin
        repeat (done_delay) begin @(posedge clk); #1; end
        done_auto = 1'b1;
        done_cyc  = cyc;
        @(posedge clk); #1;
        done_auto = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    data[ch*DW +: DW] = v;
  endtask

  task automatic push(input logic [1:0] ch, input logic [DW-1:0] v);
    exp_q.push_back({ch, v});
  endtask

  task automatic wait_starts(input int target, input int budget, input bit auto_drop);
    int n;
    n = 0;
    while (start_cnt < target && n < budget) begin
      tick();
      if (auto_drop) req = req & ~ack;
      n++;
    end
    check("starts_reached", {31'b0, (start_cnt >= target)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},     ack,         0);
    check({tag, "_start"},   tx_start,    0);
    check({tag, "_din"},     tx_din,      0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_owner"},   owner,       0);
    check({tag, "_timeout"}, timeout_err, 0);
    check({tag, "_state"},   state,       0);
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int to_cyc;
    int s;
    int a1;
    rst = 1'b1; req = '0; data = '0; done_force = 1'b0; done_delay = 10;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: lone requester 2, exactly one start before tx_done
    set_data(2, 8'hA5);
    req = 4'b0100;
    push(2'd2, 8'hA5);
    tick();
    check("t1_tx_start", tx_start, 1);
    check("t1_ack",      ack,      4'b0100);
    check("t1_din",      tx_din,   8'hA5);
    check("t1_busy",     busy,     1);
    req = '0;
    repeat (20) tick();
    check("t1_single_start", start_cnt, 1);
    check("t1_idle_busy",    busy,      0);

    // 2: all requesting from pointer 0 -> 0,1,2,3,0,1
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < NR; i++) set_data(i, 8'h10 + 8'(i));
    push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12);
    push(2'd3, 8'h13); push(2'd0, 8'h10); push(2'd1, 8'h11);
    req = 4'hF;
    wait_starts(start_cnt + 6, 200, 1'b0);
    req = '0;
    repeat (20) tick();
    check("t2_idle_busy", busy, 0);

    // 3: gap of 3 -> next start exactly 5 cycles after tx_done
    set_data(0, 8'h3C);
    push(2'd0, 8'h3C); push(2'd0, 8'h3C);
    req = 4'b0001;
    wait_starts(start_cnt + 2, 100, 1'b0);
    req = '0;
    check("t3_gap_latency", last_start_cyc - done_cyc, 5);
    repeat (20) tick();

    // 4: watchdog abort after 32 WAIT cycles, pointer stays advanced
    done_delay = 0;
    set_data(1, 8'h77);
    push(2'd1, 8'h77);
    req = 4'b0010;
    wait_starts(start_cnt + 1, 10, 1'b1);
    s = last_start_cyc;
    to_cyc = -1;
    for (int n = 0; n < 60 && to_cyc < 0; n++) begin
      tick();
      if (timeout_err) begin
        to_cyc = cyc;
        check("t4_busy_at_abort",  busy,  0);
        check("t4_state_at_abort", state, 0);
      end
    end
    check("t4_timeout_cycle", to_cyc - s, 33);
    tick();
    check("t4_pulse_width", timeout_err, 0);
    done_delay = 10;
    set_data(1, 8'h11); set_data(2, 8'h22);
    push(2'd2, 8'h22);
    req = 4'b0110;
    wait_starts(start_cnt + 1, 10, 1'b0);
    req = '0;
    repeat (20) tick();

    // 5: reset while in WAIT, then pointer restarts at 0
    done_delay = 0;
    set_data(3, 8'hC3);
    push(2'd3, 8'hC3);
    req = 4'b1000;
    wait_starts(start_cnt + 1, 10, 1'b1);
    repeat (3) tick();
    check("t5_in_wait", state, 2);
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    done_delay = 10;
    set_data(0, 8'h81); set_data(3, 8'h93);
    push(2'd0, 8'h81); push(2'd3, 8'h93);
    req = 4'b1001;
    wait_starts(start_cnt + 2, 100, 1'b1);
    req = '0;
    repeat (20) tick();

    // 6: brief req[1] during a frame is never granted; stray tx_done ignored
    set_data(0, 8'h5A);
    push(2'd0, 8'h5A);
    a1 = ack1_cnt;
    req = 4'b0001;
    wait_starts(start_cnt + 1, 10, 1'b1);
    set_data(1, 8'hEE);
    req = 4'b0010;
    tick();
    req = '0;
    repeat (25) tick();
    check("t6_no_ack1", ack1_cnt - a1, 0);
    check("t6_idle",    busy,          0);
    done_force = 1'b1;
    tick();
    done_force = 1'b0;
    check("t6_stray_done_start", tx_start, 0);
    check("t6_stray_done_state", state,    0);
    tick();
    check("t6_stray_done_busy",  busy,     0);
    check("t6_owner",            owner,    0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
